// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
// onehot_to_idx covers the widest legal configuration, so callers zero-extend their vector.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int MAX_N = 16;

    function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_pick.sv
// Circular priority pick: rotate so ptr is at bit 0, take lowest set bit, rotate back.
// Both rotations use a double-width shift, so no modulo or divider is needed.
module rr_pick #(
    parameter int N = 4,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_vec,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot
);

    logic [N-1:0] rot;
    logic [N-1:0] first;

    always_comb begin
        rot    = N'({req_vec, req_vec} >> ptr);
        first  = rot & (~rot + N'(1));
        onehot = N'(({first, first} << ptr) >> N);
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter issuing one registered one-hot grant at a time, with a
// valid/ready handshake to the consumer and a per-requester ack strobe.
//
// state | meaning
// IDLE  | no offer pending; grant=0, grant_valid=0
// OFFER | grant holds a frozen one-hot offer until out_ready
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    input  logic         out_ready,
    output logic [N-1:0] ack
);

    localparam int PTR_W = $clog2(N);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_inc, pick_ptr;
    logic [N-1:0]       grant_q, grant_d, pick_vec, nxt;
    logic [MAX_N-1:0]   grant_ext;
    int unsigned        gidx;
    logic               hs;

    assign grant       = grant_q;
    assign grant_valid = (state_q == OFFER);
    assign hs          = grant_valid & out_ready;
    assign ack         = grant_q & {N{hs}};

    // During a handshake the next pick already sees the advanced pointer and
    // excludes the requester being served this cycle.
    always_comb begin
        grant_ext          = '0;
        grant_ext[N-1:0]   = grant_q;
        gidx               = onehot_to_idx(grant_ext);
        ptr_inc            = (gidx >= N - 1) ? '0 : PTR_W'(gidx + 1);
        pick_ptr           = hs ? ptr_inc : ptr_q;
        pick_vec           = hs ? (req & ~grant_q) : req;
    end

    rr_pick #(.N(N)) u_pick (
        .req_vec (pick_vec),
        .ptr     (pick_ptr),
        .onehot  (nxt)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = nxt;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (hs) begin
                    ptr_d   = ptr_inc;
                    grant_d = nxt;
                    if (nxt == '0) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter (N=4): vector table plus starvation sequence,
// with a chained 4:2 encoder model and per-cycle invariant monitor.
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       out_ready = 1'b0;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       grant_valid;
    logic [1:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .out_ready   (out_ready),
        .ack         (ack)
    );

    // Downstream 4:2 one-hot encoder fed by grant.
    always_comb begin
        case (grant)
            4'b0001: dout = 2'd0;
            4'b0010: dout = 2'd1;
            4'b0100: dout = 2'd2;
            4'b1000: dout = 2'd3;
            default: dout = 2'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (grant_valid) check("inv_onehot_grant", 32'($onehot(grant)), 32'd1);
        else             check("inv_zero_grant", 32'(grant), 32'd0);
        check("inv_onehot0_ack", 32'($onehot0(ack)), 32'd1);
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] ack;
        logic [3:0] g;
        logic       v;
        logic [1:0] p;
    } vec_t;

    vec_t vecs[34];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic rd,
                                input logic [3:0] a, input logic [3:0] g, input logic v,
                                input logic [1:0] p);
        vec_t t;
        t.rst = r; t.req = rq; t.rdy = rd; t.ack = a; t.g = g; t.v = v; t.p = p;
        return t;
    endfunction

    int last_hs[4];
    int max_gap[4];
    int hs_count;

    initial begin
        // reset held with all requests high; then back-to-back grants
        vecs[0]  = mk(1, 4'b1111, 0, 4'b0000, 4'b0000, 0, 2'd0);
        vecs[1]  = mk(1, 4'b1111, 0, 4'b0000, 4'b0000, 0, 2'd0);
        vecs[2]  = mk(0, 4'b1111, 0, 4'b0000, 4'b0001, 1, 2'd0);
        vecs[3]  = mk(0, 4'b1111, 1, 4'b0001, 4'b0010, 1, 2'd1);
        vecs[4]  = mk(0, 4'b0000, 1, 4'b0010, 4'b0000, 0, 2'd2);
        vecs[5]  = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
        // single request, pointer lands past it
        vecs[6]  = mk(0, 4'b0100, 1, 4'b0000, 4'b0100, 1, 2'd0);
        vecs[7]  = mk(0, 4'b0000, 1, 4'b0100, 4'b0000, 0, 2'd3);
        // wrap-around from ptr=3
        vecs[8]  = mk(0, 4'b0100, 0, 4'b0000, 4'b0100, 1, 2'd3);
        vecs[9]  = mk(0, 4'b1001, 1, 4'b0100, 4'b1000, 1, 2'd3);
        vecs[10] = mk(0, 4'b1001, 1, 4'b1000, 4'b0001, 1, 2'd0);
        vecs[11] = mk(0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 2'd1);
        // full rotation, no bubbles
        vecs[12] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
        vecs[13] = mk(0, 4'b1111, 1, 4'b0000, 4'b0001, 1, 2'd0);
        vecs[14] = mk(0, 4'b1111, 1, 4'b0001, 4'b0010, 1, 2'd1);
        vecs[15] = mk(0, 4'b1111, 1, 4'b0010, 4'b0100, 1, 2'd2);
        vecs[16] = mk(0, 4'b1111, 1, 4'b0100, 4'b1000, 1, 2'd3);
        vecs[17] = mk(0, 4'b1111, 1, 4'b1000, 4'b0001, 1, 2'd0);
        vecs[18] = mk(0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 2'd1);
        // stall: offer frozen while requests change
        vecs[19] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
        vecs[20] = mk(0, 4'b0011, 0, 4'b0000, 4'b0001, 1, 2'd0);
        vecs[21] = mk(0, 4'b0011, 0, 4'b0000, 4'b0001, 1, 2'd0);
        vecs[22] = mk(0, 4'b0010, 0, 4'b0000, 4'b0001, 1, 2'd0);
        vecs[23] = mk(0, 4'b0010, 0, 4'b0000, 4'b0001, 1, 2'd0);
        vecs[24] = mk(0, 4'b0010, 1, 4'b0001, 4'b0010, 1, 2'd1);
        vecs[25] = mk(0, 4'b0000, 1, 4'b0010, 4'b0000, 0, 2'd2);
        // reset coincident with a handshake
        vecs[26] = mk(0, 4'b1111, 0, 4'b0000, 4'b0100, 1, 2'd2);
        vecs[27] = mk(1, 4'b1111, 1, 4'b0100, 4'b0000, 0, 2'd0);
        vecs[28] = mk(0, 4'b1111, 0, 4'b0000, 4'b0001, 1, 2'd0);
        vecs[29] = mk(0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 2'd1);
        // held request re-arbitrates after a one-cycle bubble
        vecs[30] = mk(0, 4'b0001, 1, 4'b0000, 4'b0001, 1, 2'd1);
        vecs[31] = mk(0, 4'b0001, 1, 4'b0001, 4'b0000, 0, 2'd1);
        vecs[32] = mk(0, 4'b0001, 1, 4'b0000, 4'b0001, 1, 2'd1);
        vecs[33] = mk(0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 2'd1);

        rst = 1'b1;
        req = 4'b1111;
        out_ready = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 34; i++) begin
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            #1;
            check($sformatf("ack[%0d]", i), 32'(ack), 32'(vecs[i].ack));
            @(posedge clk); #1;
            check($sformatf("grant[%0d]", i), 32'(grant), 32'(vecs[i].g));
            check($sformatf("valid[%0d]", i), 32'(grant_valid), 32'(vecs[i].v));
            check($sformatf("ptr[%0d]", i), 32'(dut.ptr_q), 32'(vecs[i].p));
            if (vecs[i].v)
                check($sformatf("dout[%0d]", i), 32'(dout), 32'(arb_pkg::onehot_to_idx(16'(vecs[i].g))));
        end

        // starvation: all requests held, consumer ready two cycles in three
        for (int j = 0; j < 4; j++) begin
            last_hs[j] = 0;
            max_gap[j] = 0;
        end
        hs_count = 0;
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c % 3 != 0);
            #1;
            if (ack != 4'b0000) begin
                hs_count++;
                for (int j = 0; j < 4; j++) begin
                    if (ack[j]) begin
                        if (hs_count - last_hs[j] > max_gap[j]) max_gap[j] = hs_count - last_hs[j];
                        last_hs[j] = hs_count;
                    end
                end
            end
            @(posedge clk); #1;
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("starve_gap[%0d]", j), 32'(max_gap[j] >= 1 && max_gap[j] <= 4), 32'd1);
            check($sformatf("starve_recent[%0d]", j), 32'(hs_count - last_hs[j] < 4), 32'd1);
        end

        req = 4'b0000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 32'(grant_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
